// File: rtl/pc_fetch_stage_pkg.sv
// Shared state encoding and reset constants for the MIPS IF stage.
// Imported by pc_fetch_stage; the FSM states are FETCH/HOLD/DROP.
package pc_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_HOLD  = 2'd1,
        IF_DROP  = 2'd2
    } if_state_t;

    localparam int          IF_ADDR_W_DEF   = 32;
    localparam int          IF_DATA_W_DEF   = 32;
    localparam logic [31:0] IF_RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_stage_mux2x1.sv
// Generic two-input mux; the IF stage uses it to pick pc+4 vs branch target.
module mux2x1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/pc_fetch_stage.sv
// IF stage: owns the PC, issues one imem request per PC, fills IF/ID.
// Handles ID stall (via a one-entry skid buffer), delayed branches and flush.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W_DEF,
    parameter int                DATA_W   = IF_DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_flush_pc,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic [ADDR_W-1:0] o_id_pc,
    output logic [DATA_W-1:0] o_id_inst,
    output logic              o_id_valid
);

    if_state_t         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_drop_addr;
    logic [ADDR_W-1:0] r_br_tgt;
    logic              r_br_pend;
    logic [DATA_W-1:0] r_skid;
    logic [ADDR_W-1:0] r_id_pc;
    logic [DATA_W-1:0] r_id_inst;
    logic              r_id_valid;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_dest;
    logic              w_br_sel;
    logic [ADDR_W-1:0] w_next_pc;

    // A pending redirect wins over a fresh branch pulse; either one steers
    // the PC only when the delay slot is handed to ID.
    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_br_dest  = r_br_pend ? r_br_tgt : i_branch_target;
    assign w_br_sel   = r_br_pend | i_branch_taken;

    mux2x1 #(.WIDTH(ADDR_W)) u_next_pc_mux (
        .i_a   (w_pc_plus4),
        .i_b   (w_br_dest),
        .i_sel (w_br_sel),
        .o_y   (w_next_pc)
    );

    assign o_imem_req  = !i_rst && (r_state != IF_HOLD);
    assign o_imem_addr = (r_state == IF_DROP) ? r_drop_addr : r_pc;
    assign o_id_pc     = r_id_pc;
    assign o_id_inst   = r_id_inst;
    assign o_id_valid  = r_id_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IF_FETCH;
            r_pc        <= RESET_PC;
            r_drop_addr <= '0;
            r_br_tgt    <= '0;
            r_br_pend   <= 1'b0;
            r_skid      <= '0;
            r_id_pc     <= '0;
            r_id_inst   <= '0;
            r_id_valid  <= 1'b0;
        end else if (i_flush) begin
            r_id_valid <= 1'b0;
            r_skid     <= '0;
            r_br_pend  <= 1'b0;
            r_pc       <= i_flush_pc & ~ADDR_W'(3);
            // An unanswered request must still be retired before refetching.
            if (o_imem_req && !i_imem_ack) begin
                r_state     <= IF_DROP;
                r_drop_addr <= o_imem_addr;
            end else begin
                r_state <= IF_FETCH;
            end
        end else begin
            if (i_branch_taken) begin
                r_br_pend <= 1'b1;
                r_br_tgt  <= i_branch_target;
            end
            case (r_state)
                IF_FETCH: begin
                    if (i_imem_ack && !i_stall) begin
                        r_id_inst  <= i_imem_rdata;
                        r_id_pc    <= r_pc;
                        r_id_valid <= 1'b1;
                        r_pc       <= w_next_pc;
                        r_br_pend  <= 1'b0;
                    end else if (i_imem_ack) begin
                        r_skid  <= i_imem_rdata;
                        r_state <= IF_HOLD;
                    end else if (!i_stall) begin
                        r_id_valid <= 1'b0;
                    end
                end
                IF_HOLD: begin
                    if (!i_stall) begin
                        r_id_inst  <= r_skid;
                        r_id_pc    <= r_pc;
                        r_id_valid <= 1'b1;
                        r_pc       <= w_next_pc;
                        r_br_pend  <= 1'b0;
                        r_state    <= IF_FETCH;
                    end
                end
                IF_DROP: begin
                    if (i_imem_ack) begin
                        r_state <= IF_FETCH;
                    end
                end
                default: r_state <= IF_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios plus a randomized run checked
// against a program-order model (expected next PC, delayed redirect, flush).
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int n_pass  = 0;
    int n_total = 0;

    pc_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_flush_pc      (flush_pc),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_ack      (imem_ack),
        .i_imem_rdata    (imem_rdata),
        .o_id_pc         (id_pc),
        .o_id_inst       (id_inst),
        .o_id_valid      (id_valid)
    );

    always #5 clk = ~clk;

    // Memory image: every word is a distinct function of its address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ack, input bit stl);
        imem_ack   = ack;
        stall      = stl;
        imem_rdata = ack ? inst_of(imem_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; flush_pc = '0; branch_taken = 1'b0; branch_target = '0;
        drive(1'b0, 1'b0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; flush_pc = '0; branch_taken = 1'b0; branch_target = '0;
        drive(1'b1, 1'b0);
        cyc();
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else n_pass++;
        n_total++; if (id_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", id_valid); else n_pass++;
        n_total++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc got=%h exp=0", id_pc); else n_pass++;
        n_total++; if (id_inst !== 32'h0) $display("FAIL reset_id_inst got=%h exp=0", id_inst); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", imem_addr); else n_pass++;
        cyc();
        rst = 1'b0;
        drive(1'b0, 1'b0);
        #1;
        n_total++; if (imem_req !== 1'b1) $display("FAIL reset_release_req got=%b exp=1", imem_req); else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            e = 32'(4 * i);
            n_total++; if (imem_req !== 1'b1 || imem_addr !== e) $display("FAIL seq_addr got=%b/%h exp=1/%h", imem_req, imem_addr, e); else n_pass++;
            drive(1'b1, 1'b0);
            cyc();
            n_total++; if (id_valid !== 1'b1 || id_pc !== e || id_inst !== inst_of(e)) $display("FAIL seq_ifid got=%b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_inst, e, inst_of(e)); else n_pass++;
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_ack_delay();
        do_reset();
        drive(1'b1, 1'b0); cyc();
        drive(1'b1, 1'b0); cyc();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0); cyc();
            n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || id_valid !== 1'b0) $display("FAIL delay_wait got=%b/%h/%b exp=1/00000008/0", imem_req, imem_addr, id_valid); else n_pass++;
        end
        drive(1'b1, 1'b0); cyc();
        n_total++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_inst !== inst_of(32'h8)) $display("FAIL delay_deliver got=%b/%h exp=1/00000008", id_valid, id_pc); else n_pass++;
        drive(1'b0, 1'b0);
    endtask

    task automatic test_branch();
        do_reset();
        drive(1'b1, 1'b0); cyc();
        drive(1'b1, 1'b0); cyc();
        drive(1'b1, 1'b0); branch_taken = 1'b1; branch_target = 32'h40;
        cyc();
        branch_taken = 1'b0;
        n_total++; if (id_valid !== 1'b1 || id_pc !== 32'h8) $display("FAIL br_delay_slot got=%b/%h exp=1/00000008", id_valid, id_pc); else n_pass++;
        n_total++; if (imem_addr !== 32'h40) $display("FAIL br_target_addr got=%h exp=00000040", imem_addr); else n_pass++;
        drive(1'b1, 1'b0); cyc();
        n_total++; if (id_pc !== 32'h40 || imem_addr !== 32'h44) $display("FAIL br_after got=%h/%h exp=00000040/00000044", id_pc, imem_addr); else n_pass++;
        // branch resolved while the delay-slot fetch is still waiting
        drive(1'b0, 1'b0); branch_taken = 1'b1; branch_target = 32'h100;
        cyc();
        branch_taken = 1'b0;
        n_total++; if (id_valid !== 1'b0 || imem_addr !== 32'h44) $display("FAIL br_pend_wait got=%b/%h exp=0/00000044", id_valid, imem_addr); else n_pass++;
        drive(1'b0, 1'b0); cyc();
        drive(1'b1, 1'b0); cyc();
        n_total++; if (id_valid !== 1'b1 || id_pc !== 32'h44 || imem_addr !== 32'h100) $display("FAIL br_pend_apply got=%b/%h/%h exp=1/00000044/00000100", id_valid, id_pc, imem_addr); else n_pass++;
        drive(1'b1, 1'b0); cyc();
        n_total++; if (id_pc !== 32'h100 || id_inst !== inst_of(32'h100)) $display("FAIL br_pend_target got=%h exp=00000100", id_pc); else n_pass++;
        drive(1'b0, 1'b0);
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0); cyc(); end
        drive(1'b1, 1'b1); cyc();
        n_total++; if (id_pc !== 32'h8 || id_valid !== 1'b1 || imem_req !== 1'b0) $display("FAIL stall_hold1 got=%h/%b/%b exp=00000008/1/0", id_pc, id_valid, imem_req); else n_pass++;
        drive(1'b0, 1'b1); cyc();
        n_total++; if (id_pc !== 32'h8 || imem_req !== 1'b0) $display("FAIL stall_hold2 got=%h/%b exp=00000008/0", id_pc, imem_req); else n_pass++;
        drive(1'b0, 1'b0); cyc();
        n_total++; if (id_pc !== 32'hC || id_inst !== inst_of(32'hC) || id_valid !== 1'b1) $display("FAIL stall_release got=%h/%h/%b exp=0000000c/%h/1", id_pc, id_inst, id_valid, inst_of(32'hC)); else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) $display("FAIL stall_next_addr got=%b/%h exp=1/00000010", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0); cyc(); end
        drive(1'b0, 1'b0); flush = 1'b1; flush_pc = 32'h83;
        cyc();
        flush = 1'b0;
        n_total++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) $display("FAIL flush_drop got=%b/%b/%h exp=0/1/00000010", id_valid, imem_req, imem_addr); else n_pass++;
        drive(1'b0, 1'b0); cyc();
        n_total++; if (imem_addr !== 32'h10) $display("FAIL flush_drop_hold got=%h exp=00000010", imem_addr); else n_pass++;
        drive(1'b1, 1'b0); cyc();
        n_total++; if (id_valid !== 1'b0 || imem_addr !== 32'h80) $display("FAIL flush_discard got=%b/%h exp=0/00000080", id_valid, imem_addr); else n_pass++;
        drive(1'b1, 1'b0); cyc();
        n_total++; if (id_valid !== 1'b1 || id_pc !== 32'h80 || id_inst !== inst_of(32'h80)) $display("FAIL flush_refetch got=%b/%h exp=1/00000080", id_valid, id_pc); else n_pass++;
        // flush and stall together while holding: flush wins
        drive(1'b1, 1'b1); cyc();
        drive(1'b0, 1'b1); flush = 1'b1; flush_pc = 32'hFFFF_FFFE;
        cyc();
        flush = 1'b0;
        n_total++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) $display("FAIL flush_over_stall got=%b/%b/%h exp=0/1/fffffffc", id_valid, imem_req, imem_addr); else n_pass++;
        drive(1'b1, 1'b0); cyc();
        n_total++; if (id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) $display("FAIL pc_wrap got=%h/%h exp=fffffffc/00000000", id_pc, imem_addr); else n_pass++;
        drive(1'b0, 1'b0);
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        drive(1'b1, 1'b0); cyc();
        drive(1'b1, 1'b0); cyc();
        drive(1'b1, 1'b1); cyc();
        rst = 1'b1;
        drive(1'b0, 1'b1);
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL rsthold_req_now got=%b exp=0", imem_req); else n_pass++;
        cyc();
        n_total++; if (id_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) $display("FAIL rsthold_state got=%b/%b/%h exp=0/0/00000000", id_valid, imem_req, imem_addr); else n_pass++;
        rst = 1'b0;
        drive(1'b0, 1'b0);
        #1;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rsthold_resume got=%b/%h exp=1/00000000", imem_req, imem_addr); else n_pass++;
        drive(1'b1, 1'b0); cyc();
        n_total++; if (id_valid !== 1'b1 || id_pc !== 32'h0) $display("FAIL rsthold_first got=%b/%h exp=1/00000000", id_valid, id_pc); else n_pass++;
        drive(1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] exp_next, redir_after, redir_tgt, p_addr, pv_pc, pv_inst;
        bit redir, holding, dropping, p_flush, p_stall, p_deliver, p_wait, pv_valid;
        bit st, fl, ak, br;
        bit n_hold, n_drop;
        do_reset();
        exp_next = 32'h0; redir = 1'b0; redir_after = '0; redir_tgt = '0;
        holding = 1'b0; dropping = 1'b0;
        p_flush = 1'b0; p_stall = 1'b0; p_deliver = 1'b0; p_wait = 1'b0; p_addr = '0;
        pv_valid = 1'b0; pv_pc = '0; pv_inst = '0;
        for (int i = 0; i < 2000; i++) begin
            if (i > 0) begin
                if (p_flush) begin
                    n_total++; if (id_valid !== 1'b0) $display("FAIL rnd_flush_clear cyc=%0d got=%b exp=0", i, id_valid); else n_pass++;
                end else if (p_stall) begin
                    n_total++; if ({id_valid, id_pc, id_inst} !== {pv_valid, pv_pc, pv_inst}) $display("FAIL rnd_stall_hold cyc=%0d got=%b/%h/%h exp=%b/%h/%h", i, id_valid, id_pc, id_inst, pv_valid, pv_pc, pv_inst); else n_pass++;
                end else if (p_deliver) begin
                    n_total++; if (id_valid !== 1'b1 || id_pc !== exp_next || id_inst !== inst_of(exp_next)) $display("FAIL rnd_deliver cyc=%0d got=%b/%h/%h exp=1/%h/%h", i, id_valid, id_pc, id_inst, exp_next, inst_of(exp_next)); else n_pass++;
                    if (redir && exp_next == redir_after) begin
                        exp_next = redir_tgt;
                        redir = 1'b0;
                    end else begin
                        exp_next = exp_next + 32'd4;
                    end
                end else begin
                    n_total++; if (id_valid !== 1'b0) $display("FAIL rnd_bubble cyc=%0d got=%b exp=0", i, id_valid); else n_pass++;
                end
            end
            n_total++; if (imem_req !== !holding) $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, imem_req, !holding); else n_pass++;
            if (p_wait) begin
                n_total++; if (imem_addr !== p_addr) $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", i, imem_addr, p_addr); else n_pass++;
            end

            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 39) == 0);
            ak = !holding && ($urandom_range(0, 1) == 1);
            br = !fl && !st && !holding && !dropping && !redir && id_valid && ($urandom_range(0, 5) == 0);
            drive(ak, st);
            flush         = fl;
            flush_pc      = $urandom;
            branch_taken  = br;
            branch_target = $urandom & 32'hFFFF_FFFC;

            p_flush   = fl;
            p_stall   = st;
            p_deliver = !fl && !st && (holding || (ak && !dropping));
            p_wait    = !holding && !ak;
            p_addr    = imem_addr;
            pv_valid  = id_valid; pv_pc = id_pc; pv_inst = id_inst;
            if (fl) begin
                exp_next = flush_pc & 32'hFFFF_FFFC;
                redir    = 1'b0;
            end
            if (br) begin
                redir       = 1'b1;
                redir_after = exp_next;
                redir_tgt   = branch_target;
            end
            n_hold = fl ? 1'b0 : (holding ? st : (ak && st && !dropping));
            n_drop = fl ? (!holding && !ak) : (dropping && !ak);
            holding  = n_hold;
            dropping = n_drop;
            cyc();
        end
        flush = 1'b0; branch_taken = 1'b0;
        drive(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ack_delay();
        test_branch();
        test_stall();
        test_flush();
        test_reset_in_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
